// File: rtl/flash_ctrl.sv
// Parallel NOR flash sequencer: power-up reset pulse, then single-word reads.
// Define FLASH_CTRL_WRITE_EN to enable the write path (req_we=1 -> WR).
//   state     | meaning
//   RST_PULSE | flash_reset_ held low
//   RST_WAIT  | flash recovering after reset
//   IDLE      | req_ready high, waiting for a request
//   SETUP     | ce_ low, address settling
//   RD        | oe_ low, data sampled on last cycle
//   WR        | we_ low, address/data held (write build only)
//   DONE      | strobes released, rsp_valid pulse
//   REC       | bus turnaround before next access
module flash_ctrl #(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned RST_RECOV  = 8,
  parameter int unsigned RD_WAIT    = 3,
  parameter int unsigned WR_WAIT    = 2,
  parameter int unsigned TURN       = 1
) (
  input  logic        clk25,
  input  logic        rst_,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [20:0] req_addr,
  input  logic        req_we,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        flash_reset_,
  output logic        flash_ce_,
  output logic        flash_oe_,
  output logic        flash_we_,
  output logic [20:0] flash_a,
  output logic [15:0] flash_dq_o,
  output logic        flash_dq_oe,
  input  logic [15:0] flash_dq_i
);

  localparam logic [2:0] S_RST_PULSE = 3'd0;
  localparam logic [2:0] S_RST_WAIT  = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_SETUP     = 3'd3;
  localparam logic [2:0] S_RD        = 3'd4;
`ifdef FLASH_CTRL_WRITE_EN
  localparam logic [2:0] S_WR        = 3'd5;
`endif
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_REC       = 3'd7;

  // The counter leaves reset at 0 and wraps downward during RST_PULSE,
  // so the terminal count is RST_CYCLES decrements below zero.
  localparam logic [7:0] RST_TC   = 8'(256 - RST_CYCLES);
  localparam logic [7:0] RECOV_LD = 8'(RST_RECOV - 1);
  localparam logic [7:0] RD_LD    = 8'(RD_WAIT - 1);
  localparam logic [7:0] TURN_LD  = 8'(TURN - 1);

  logic [2:0] state;
  logic [7:0] cnt;

`ifdef FLASH_CTRL_WRITE_EN
  localparam logic [7:0] WR_LD = 8'(WR_WAIT - 1);
  logic is_write;
`else
  logic unused_wr;
  assign unused_wr = ^{req_we, req_wdata};
`endif

  always_ff @(posedge clk25) begin
    if (!rst_) begin
      state        <= S_RST_PULSE;
      cnt          <= 8'd0;
      flash_reset_ <= 1'b0;
      flash_ce_    <= 1'b1;
      flash_oe_    <= 1'b1;
      flash_we_    <= 1'b1;
      flash_a      <= 21'd0;
      flash_dq_o   <= 16'd0;
      flash_dq_oe  <= 1'b0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 16'd0;
`ifdef FLASH_CTRL_WRITE_EN
      is_write     <= 1'b0;
`endif
    end else begin
      case (state)
        S_RST_PULSE: begin
          if (cnt == RST_TC) begin
            flash_reset_ <= 1'b1;
            cnt          <= RECOV_LD;
            state        <= S_RST_WAIT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_RST_WAIT: begin
          if (cnt == 8'd0) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            flash_a   <= req_addr;
            flash_ce_ <= 1'b0;
            state     <= S_SETUP;
`ifdef FLASH_CTRL_WRITE_EN
            is_write  <= req_we;
            if (req_we) begin
              flash_dq_o  <= req_wdata;
              flash_dq_oe <= 1'b1;
            end
`endif
          end
        end
        S_SETUP: begin
`ifdef FLASH_CTRL_WRITE_EN
          if (is_write) begin
            flash_we_ <= 1'b0;
            cnt       <= WR_LD;
            state     <= S_WR;
          end else
`endif
          begin
            flash_oe_ <= 1'b0;
            cnt       <= RD_LD;
            state     <= S_RD;
          end
        end
        S_RD: begin
          if (cnt == 8'd0) begin
            rsp_rdata <= flash_dq_i;
            flash_oe_ <= 1'b1;
            flash_ce_ <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
`ifdef FLASH_CTRL_WRITE_EN
        S_WR: begin
          if (cnt == 8'd0) begin
            flash_we_ <= 1'b1;
            flash_ce_ <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
`endif
        S_DONE: begin
          rsp_valid   <= 1'b0;
          flash_dq_oe <= 1'b0;
          cnt         <= TURN_LD;
          state       <= S_REC;
        end
        S_REC: begin
          if (cnt == 8'd0) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_RST_PULSE;
      endcase
    end
  end

endmodule
